sync_fifo_flags: RTL

Parametrised single-clock FIFO, the next generation of the team's basic sync FIFO.
- Adds generic width/depth, an occupancy count, almost-full and almost-empty thresholds, and overflow/underflow error pulses.
- Defines simultaneous read/write at the full and empty boundaries.
- Sits between producer and consumer logic in the same clock domain. Used wherever the plain FIFO is replaced.

---
 rtl/sync_fifo_pkg.sv | 23 ++
 rtl/sync_fifo_flags_if.sv | 43 ++++
 rtl/sync_fifo_flags_mem.sv | 33 +++
 rtl/sync_fifo_flags.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and helpers for the sync_fifo_flags FIFO.
//   ptr_w()         : pointer/count width for a given depth (index bits + wrap bit)
//   DEF_* constants : default width, depth and almost-empty threshold
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_AE_THRESH = 2;

    // Index bits plus one wrap bit; also wide enough to hold 0..Depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // The default almost-full threshold sits two entries below full.
    function automatic int def_af_thresh(input int depth);
        return depth - 2;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags_if
// Producer/consumer bus of the sync_fifo_flags FIFO.
//   write_en, d_in                 : push side
//   read_en, d_out                 : pop side
//   full, empty, almost_full,
//   almost_empty, count            : registered occupancy status
//   overflow, underflow            : one-cycle error pulses
// Modports: master (the logic using the FIFO), slave (the FIFO itself).
// ---------------------------------------------------------------------------
interface sync_fifo_flags_if
    import sync_fifo_pkg::*;
#(
    parameter int Width = DEF_WIDTH,
    parameter int Depth = DEF_DEPTH
);
    localparam int CW = ptr_w(Depth);

    logic             write_en;
    logic             read_en;
    logic [Width-1:0] d_in;
    logic [Width-1:0] d_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output write_en, read_en, d_in,
        input  d_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  write_en, read_en, d_in,
        output d_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_flags_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem_2p
// Register-array storage for the FIFO: one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
//   clk          : write clock
//   we, waddr,
//   wdata        : write port, sampled on the rising edge
//   raddr, rdata : combinational read port
// ---------------------------------------------------------------------------
module fifo_mem_2p #(
    parameter  int Width = 16,
    parameter  int Depth = 8,
    localparam int AW    = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and
// overflow/underflow error pulses.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset (clears pointers, count, flags,
//         d_out; storage is left untouched)
//   bus : sync_fifo_flags_if.slave (push/pop handshake, data, status)
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (head word shown on d_out combinationally, 0 while empty). Without it,
// d_out is registered with one cycle of read latency.
// ---------------------------------------------------------------------------
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int Width     = DEF_WIDTH,
    parameter int Depth     = DEF_DEPTH,
    parameter int AF_THRESH = def_af_thresh(Depth),
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_flags_if.slave bus
);

    localparam int PW = ptr_w(Depth);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic [PW-1:0]    count_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic [Width-1:0] rd_data;
    logic             full_q;
    logic             empty_q;
    logic             almost_full_q;
    logic             almost_empty_q;
    logic             overflow_q;
    logic             underflow_q;

`ifndef SYNTHESIS
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_depth_chk
        $error("sync_fifo_flags: Depth must be a power of 2 and at least 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > Depth) begin : g_af_chk
        $error("sync_fifo_flags: AF_THRESH must lie in 0..Depth");
    end
    if (AE_THRESH < 0 || AE_THRESH > Depth) begin : g_ae_chk
        $error("sync_fifo_flags: AE_THRESH must lie in 0..Depth");
    end
`endif

    // A read on a full FIFO frees the slot the write lands in, so both go
    // through. On an empty FIFO the write is taken but the read is refused.
    assign wr_acc    = bus.write_en & (~full_q | bus.read_en);
    assign rd_acc    = bus.read_en & ~empty_q;
    assign count_nxt = count + PW'(wr_acc) - PW'(rd_acc);

    fifo_mem_2p #(
        .Width (Width),
        .Depth (Depth)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.d_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    // Pointers, count and flags: flags come from the next count so they
    // change on the same edge as count itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count          <= count_nxt;
            full_q         <= (count_nxt == PW'(Depth));
            empty_q        <= (count_nxt == '0);
            almost_full_q  <= (count_nxt >= PW'(AF_THRESH));
            almost_empty_q <= (count_nxt <= PW'(AE_THRESH));
            overflow_q     <= bus.write_en & full_q & ~bus.read_en;
            underflow_q    <= bus.read_en & empty_q;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word falls through to the output; blank while nothing is stored.
    assign bus.d_out = empty_q ? '0 : rd_data;
`else
    logic [Width-1:0] d_out_p0;

    // Output register: loads the head word on an accepted read, else holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out_p0 <= '0;
        end else if (rd_acc) begin
            d_out_p0 <= rd_data;
        end
    end

    assign bus.d_out = d_out_p0;
`endif

    assign bus.count        = count;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
